// File: rtl/ni_packet_tx_pkg.sv
// ---------------------------------------------------------------------------
// ni_packet_tx_pkg
// Shared types for the network-interface packet transmitter: flit format,
// router address, transmitter FSM states and the latched packet request.
// A flit is {valid, flit_type[1:0], data[15:0]} = 19 bits.
// ---------------------------------------------------------------------------
package ni_packet_tx_pkg;

    localparam int FLIT_DATA_BITS = 16;
    localparam int PAYLOAD_BITS   = 2 * FLIT_DATA_BITS;

    typedef enum logic [1:0] {
        TAIL_FLIT = 2'b00,
        BODY_FLIT = 2'b01,
        HEAD_FLIT = 2'b10
    } FLIT_TYPE_t;

    typedef struct packed {
        logic                      valid;
        FLIT_TYPE_t                flit_type;
        logic [FLIT_DATA_BITS-1:0] data;
    } FLIT_t;

    typedef struct packed {
        logic [7:0] xaddr;
        logic [7:0] yaddr;
    } ROUTER_CONFIG;

    typedef enum logic [2:0] {
        NI_IDLE,
        NI_SEND_HEAD,
        NI_SEND_BODY1,
        NI_SEND_BODY2,
        NI_SEND_TAIL
    } NI_TX_STATE_t;

    typedef struct packed {
        ROUTER_CONFIG              dest;
        logic [PAYLOAD_BITS-1:0]   payload;
    } NI_PKT_REQ_t;

endpackage

// File: rtl/ni_packet_tx_if.sv
// ---------------------------------------------------------------------------
// ni_packet_tx_if
// Core-side packet request and router-side flit link of the NI transmitter.
//   pkt_valid/pkt_ready  request handshake, pkt_dest/pkt_payload request data
//   flit/flit_req        offered flit (flit_req mirrors flit.valid)
//   flit_ack             router accepts the offered flit
// master: core + router side.  slave: the transmitter.
// ---------------------------------------------------------------------------
interface ni_packet_tx_if;
    import ni_packet_tx_pkg::*;

    logic                    pkt_valid;
    logic                    pkt_ready;
    ROUTER_CONFIG            pkt_dest;
    logic [PAYLOAD_BITS-1:0] pkt_payload;
    FLIT_t                   flit;
    logic                    flit_req;
    logic                    flit_ack;

    modport master (
        output pkt_valid, pkt_dest, pkt_payload, flit_ack,
        input  pkt_ready, flit, flit_req
    );

    modport slave (
        input  pkt_valid, pkt_dest, pkt_payload, flit_ack,
        output pkt_ready, flit, flit_req
    );

endinterface

// File: rtl/ni_flit_builder.sv
// ---------------------------------------------------------------------------
// ni_flit_builder
// Combinational flit formatter: maps a transmitter state and latched request
// to the flit offered in that state (all-zero flit in IDLE).
//   state_i  transmitter state
//   req_i    latched destination + payload
//   flit_o   formatted flit
// Build option NI_TAIL_CHECKSUM_EN: tail data is the XOR of the two payload
// halves; otherwise the tail carries zero.
// ---------------------------------------------------------------------------
module ni_flit_builder
    import ni_packet_tx_pkg::*;
(
    input  NI_TX_STATE_t state_i,
    input  NI_PKT_REQ_t  req_i,
    output FLIT_t        flit_o
);

    logic [FLIT_DATA_BITS-1:0] tail_data;

`ifdef NI_TAIL_CHECKSUM_EN
    assign tail_data = req_i.payload[PAYLOAD_BITS-1:FLIT_DATA_BITS]
                     ^ req_i.payload[FLIT_DATA_BITS-1:0];
`else
    assign tail_data = '0;
`endif

    always_comb begin
        flit_o = '0;
        case (state_i)
            NI_SEND_HEAD: begin
                flit_o.valid     = 1'b1;
                flit_o.flit_type = HEAD_FLIT;
                flit_o.data      = {req_i.dest.xaddr, req_i.dest.yaddr};
            end
            NI_SEND_BODY1: begin
                flit_o.valid     = 1'b1;
                flit_o.flit_type = BODY_FLIT;
                flit_o.data      = req_i.payload[PAYLOAD_BITS-1:FLIT_DATA_BITS];
            end
            NI_SEND_BODY2: begin
                flit_o.valid     = 1'b1;
                flit_o.flit_type = BODY_FLIT;
                flit_o.data      = req_i.payload[FLIT_DATA_BITS-1:0];
            end
            NI_SEND_TAIL: begin
                flit_o.valid     = 1'b1;
                flit_o.flit_type = TAIL_FLIT;
                flit_o.data      = tail_data;
            end
            default: flit_o = '0;
        endcase
    end

endmodule

// File: rtl/ni_packet_tx.sv
// ---------------------------------------------------------------------------
// ni_packet_tx
// Network-interface transmitter: accepts one packet request (dest + 32-bit
// payload) and serialises it as HEAD, BODY, BODY, TAIL onto the router local
// input with a req/ack handshake. All outputs are registered.
//   clk, rst_n       clock, asynchronous active-low reset
//   link (slave)     packet request handshake + flit link
//   busy_o           packet in flight
//   pkt_sent_cnt_o   accepted tail flits, wrapping
//   stall_err_o      sticky: STALL_LIMIT consecutive stalled cycles seen
// Build option NI_TAIL_CHECKSUM_EN (in ni_flit_builder): XOR checksum tail.
// ---------------------------------------------------------------------------
module ni_packet_tx
    import ni_packet_tx_pkg::*;
#(
    parameter int CNT_WIDTH   = 16,
    parameter int STALL_LIMIT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ni_packet_tx_if.slave        link,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] pkt_sent_cnt_o,
    output logic                 stall_err_o
);

    localparam int STALL_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

    NI_TX_STATE_t         state_q, state_d;
    NI_PKT_REQ_t          req_q, req_d;
    FLIT_t                flit_q, flit_d;
    logic                 ready_q, busy_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic                 err_q, err_d;
    logic                 xfer;

    // flit_q.valid is high exactly in the SEND_* states, so it doubles as req
    assign xfer = flit_q.valid & link.flit_ack;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        case (state_q)
            NI_IDLE: begin
                if (link.pkt_valid) begin
                    state_d      = NI_SEND_HEAD;
                    req_d.dest    = link.pkt_dest;
                    req_d.payload = link.pkt_payload;
                end
            end
            NI_SEND_HEAD:  if (xfer) state_d = NI_SEND_BODY1;
            NI_SEND_BODY1: if (xfer) state_d = NI_SEND_BODY2;
            NI_SEND_BODY2: if (xfer) state_d = NI_SEND_TAIL;
            NI_SEND_TAIL: begin
                if (xfer) begin
                    state_d = NI_IDLE;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = NI_IDLE;
        endcase
    end

    // Stall run length saturates at the limit; the error bit is sticky
    always_comb begin
        stall_d = stall_q;
        err_d   = err_q;
        if (STALL_LIMIT > 0) begin
            if (xfer)
                stall_d = '0;
            else if (flit_q.valid && stall_q != STALL_MAX)
                stall_d = stall_q + 1'b1;
            if (stall_d == STALL_MAX)
                err_d = 1'b1;
        end
    end

    // Built from next state so the output flit is a plain register
    ni_flit_builder u_builder (
        .state_i (state_d),
        .req_i   (req_d),
        .flit_o  (flit_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NI_IDLE;
            req_q   <= '0;
            flit_q  <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            flit_q  <= flit_d;
            ready_q <= (state_d == NI_IDLE);
            busy_q  <= (state_d != NI_IDLE);
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign link.pkt_ready = ready_q;
    assign link.flit      = flit_q;
    assign link.flit_req  = flit_q.valid;
    assign busy_o         = busy_q;
    assign pkt_sent_cnt_o = cnt_q;
    assign stall_err_o    = err_q;

endmodule
